// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, reset/NOP constants and the
// opcode values the decoder already relies on.
package rv32i_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_FAULT
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instruction_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: owns the PC, fetches over a variable-latency req/ack bus,
// holds one word for the decoder and handles (possibly in-flight) redirects.
module instruction_fetch_unit #(
  parameter int unsigned     XLEN      = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = rv32i_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0]     NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    reset,
  instruction_fetch_unit_if.master imem,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    instr_valid,
  output logic [31:0]             instruction,
  output logic [XLEN-1:0]         instr_pc,
  output logic [XLEN-1:0]         pc_plus_four,
  output logic                    misaligned_fault,
  output logic [XLEN-1:0]         fault_pc
);
  import rv32i_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_pending_q, pc_pending_d;
  logic            kill_q, kill_d;
  logic [31:0]     instruction_q, instruction_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] pc_plus_four_q, pc_plus_four_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic            redirect_bad;

  assign redirect_bad = redirect_valid && is_misaligned(redirect_pc[1:0]);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pc_pending_d   = pc_pending_q;
    kill_d         = kill_q;
    instruction_d  = instruction_q;
    instr_pc_d     = instr_pc_q;
    pc_plus_four_d = pc_plus_four_q;
    fault_d        = fault_q;
    fault_pc_d     = fault_pc_q;

    // A misaligned target abandons whatever is in flight and parks the unit.
    if (redirect_bad) begin
      fault_d    = 1'b1;
      fault_pc_d = redirect_pc;
      kill_d     = 1'b0;
      state_d    = S_FAULT;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem.imem_ack) begin
            if (redirect_valid) begin
              pc_d   = redirect_pc;
              kill_d = 1'b0;
            end else if (kill_q) begin
              pc_d   = pc_pending_q;
              kill_d = 1'b0;
            end else begin
              instruction_d  = imem.imem_rdata;
              instr_pc_d     = pc_q;
              pc_plus_four_d = pc_q + XLEN'(4);
              state_d        = S_HOLD;
            end
          end else if (redirect_valid) begin
            kill_d       = 1'b1;
            pc_pending_d = redirect_pc;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end else if (!stall) begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_REQ;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      pc_pending_q   <= '0;
      kill_q         <= 1'b0;
      instruction_q  <= NOP_INSTR;
      instr_pc_q     <= '0;
      pc_plus_four_q <= XLEN'(4);
      fault_q        <= 1'b0;
      fault_pc_q     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_pending_q   <= pc_pending_d;
      kill_q         <= kill_d;
      instruction_q  <= instruction_d;
      instr_pc_q     <= instr_pc_d;
      pc_plus_four_q <= pc_plus_four_d;
      fault_q        <= fault_d;
      fault_pc_q     <= fault_pc_d;
    end
  end

  assign imem.imem_req    = (state_q == S_REQ) && !reset;
  assign imem.imem_addr   = pc_q;
  assign instr_valid      = (state_q == S_HOLD);
  assign instruction      = instr_valid ? instruction_q : NOP_INSTR;
  assign instr_pc         = instr_pc_q;
  assign pc_plus_four     = pc_plus_four_q;
  assign misaligned_fault = fault_q;
  assign fault_pc         = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a variable-latency memory model
// and a program-order PC model predict each presented word; a monitor checks them.
module tb_instruction_fetch_unit;
  import rv32i_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] pc4;
  } pres_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus_four;
  logic        misaligned_fault;
  logic [31:0] fault_pc;

  instruction_fetch_unit_if #(.XLEN(32)) imem_bus ();

  instruction_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk), .reset(reset), .imem(imem_bus.master), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .pc_plus_four(pc_plus_four), .misaligned_fault(misaligned_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Stimulus knobs, set by the directed sequence.
  int unsigned lat_min = 0, lat_max = 0;
  logic        rand_redirect_en = 1'b0, rand_stall_en = 1'b0;
  logic        force_stall = 1'b0, force_redirect = 1'b0;
  logic [31:0] force_target = '0;
  logic        mem_const_en = 1'b1;
  logic [31:0] mem_const = 32'h0000_0013;

  // Reference model state: architectural next PC and the in-flight request.
  pres_t       exp_q[$];
  logic [31:0] exp_next = 32'h0, cur_pc = 32'h0, req_pc = 32'h0, fault_pc_exp = 32'h0;
  logic        busy = 1'b0, superseded = 1'b0, holding = 1'b0;
  logic        fault_arm = 1'b0, fault_active = 1'b0;
  int unsigned lat = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return mem_const_en ? mem_const : ({a[15:0], a[31:16]} ^ 32'h5A5A_1234);
  endfunction

  task automatic applyStimulus();
    logic ack_now, redir_now;
    logic [31:0] tgt;
    ack_now = 1'b0; redir_now = 1'b0; tgt = '0;
    if (reset) begin
      imem_bus.imem_ack = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
      exp_next = 32'h0; busy = 1'b0; superseded = 1'b0; holding = 1'b0;
      exp_q.delete();
      return;
    end
    if (!fault_arm && !fault_active) begin
      if (imem_bus.imem_req && !busy) begin
        checkOutput("fetch_addr", imem_bus.imem_addr, exp_next);
        busy = 1'b1; superseded = 1'b0; req_pc = exp_next;
        lat = $urandom_range(lat_max, lat_min);
      end
      if (busy) begin
        if (lat == 0) ack_now = 1'b1;
        else lat--;
      end
      if (force_redirect) begin
        redir_now = 1'b1; tgt = force_target; force_redirect = 1'b0;
      end else if (rand_redirect_en && $urandom_range(7, 0) == 0) begin
        redir_now = 1'b1; tgt = $urandom_range(1023, 0) << 2;
      end
      stall = force_stall || (rand_stall_en && $urandom_range(2, 0) == 0);
    end
    imem_bus.imem_ack   = ack_now;
    imem_bus.imem_rdata = ack_now ? memWord(req_pc) : 32'hDEAD_BEEF;
    redirect_valid      = redir_now;
    redirect_pc         = tgt;

    if (redir_now && tgt[1:0] != 2'b00) begin
      fault_arm = 1'b1; fault_pc_exp = tgt; busy = 1'b0; holding = 1'b0;
    end else begin
      if (ack_now) begin
        busy = 1'b0;
        if (!redir_now && !superseded) begin
          exp_q.push_back('{pc: req_pc, word: memWord(req_pc), pc4: req_pc + 32'd4});
          cur_pc = req_pc;
        end
      end else if (busy && redir_now) begin
        superseded = 1'b1;
      end
      if (redir_now) exp_next = tgt;
      else if (holding && !stall) exp_next = cur_pc + 32'd4;
      if (holding && (redir_now || !stall)) holding = 1'b0;
      if (ack_now && !redir_now && !superseded) holding = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      applyStimulus();
    end
  end

  // Monitor: pops one expected word per new presentation and checks the hold.
  initial begin
    pres_t mon_cur;
    logic prev_valid;
    prev_valid = 1'b0;
    mon_cur = '{pc: '0, word: '0, pc4: '0};
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_valid = 1'b0; fault_arm = 1'b0; fault_active = 1'b0;
        continue;
      end
      if (fault_active) begin
        checkOutput("fault_flag", misaligned_fault, 1);
        checkOutput("fault_pc", fault_pc, fault_pc_exp);
        checkOutput("fault_valid", instr_valid, 0);
        checkOutput("fault_req", imem_bus.imem_req, 0);
        checkOutput("fault_instr", instruction, NOP_INSTR);
      end else begin
        checkOutput("no_fault", misaligned_fault, 0);
        if (instr_valid) begin
          if (!prev_valid) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("[TB] FAIL unexpected_word actual_pc=%h expected=none at %0t", instr_pc, $time);
            end else begin
              mon_cur = exp_q.pop_front();
            end
          end
          checkOutput("instr_pc", instr_pc, mon_cur.pc);
          checkOutput("instruction", instruction, mon_cur.word);
          checkOutput("pc_plus_four", pc_plus_four, mon_cur.pc4);
          checkOutput("hold_req_low", imem_bus.imem_req, 0);
        end
        checkOutput("sb_depth_ok", (exp_q.size() <= 1) ? 32'd1 : 32'd0, 1);
      end
      prev_valid = instr_valid;
      if (fault_arm) begin fault_active = 1'b1; fault_arm = 1'b0; end
    end
  end

  task automatic stepCycle();
    @(negedge clk);
    #3;
  endtask

  task automatic doReset();
    stepCycle();
    reset = 1'b1;
    repeat (2) stepCycle();
    reset = 1'b0;
  endtask

  task automatic waitValid(input string name);
    logic was, found;
    was = instr_valid; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      stepCycle();
      if (instr_valid && !was) found = 1'b1;
      was = instr_valid;
    end
    if (!found) begin
      total++; bad++;
      $display("[TB] FAIL %s_timeout actual=no_valid expected=valid", name);
    end
  endtask

  initial begin
    logic found;
    // Reset state
    repeat (3) stepCycle();
    checkOutput("rst_req", imem_bus.imem_req, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_instr", instruction, 32'h0000_0013);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_pc4", pc_plus_four, 4);
    checkOutput("rst_fault", misaligned_fault, 0);
    checkOutput("rst_fault_pc", fault_pc, 0);

    // Zero-wait streaming: valid every other cycle, PCs 0,4,8,C.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput("valid_pattern", instr_valid, (i % 2 == 1) ? 32'd1 : 32'd0);
    end

    // 3-cycle memory, redirect to 0x100 one cycle after the request to 8.
    lat_min = 3; lat_max = 3; mem_const_en = 1'b0;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      stepCycle();
      if (imem_bus.imem_req && imem_bus.imem_addr == 32'h8) found = 1'b1;
    end
    checkOutput("saw_req_8", found, 1);
    force_target = 32'h100; force_redirect = 1'b1;
    waitValid("redir_inflight");
    checkOutput("redir_inflight_pc", instr_pc, 32'h100);

    // Stall hold for 5 cycles, then release.
    lat_min = 0; lat_max = 0; mem_const_en = 1'b1; mem_const = 32'h0020_8133;
    force_stall = 1'b1;
    doReset();
    waitValid("stall_first");
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("stall_valid", instr_valid, 1);
      checkOutput("stall_instr", instruction, 32'h0020_8133);
      checkOutput("stall_pc", instr_pc, 32'h0);
      checkOutput("stall_req", imem_bus.imem_req, 0);
    end

    // Redirect while stalled in hold.
    force_target = 32'h40; force_redirect = 1'b1;
    waitValid("stall_redir");
    checkOutput("stall_redir_pc", instr_pc, 32'h40);
    force_stall = 1'b0;

    // PC wrap at the top of the address space.
    mem_const_en = 1'b0;
    force_target = 32'hFFFF_FFFC; force_redirect = 1'b1;
    waitValid("wrap_top");
    checkOutput("wrap_top_pc", instr_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_top_pc4", pc_plus_four, 32'h0);
    waitValid("wrap_zero");
    checkOutput("wrap_zero_pc", instr_pc, 32'h0);

    // Randomized traffic.
    lat_min = 0; lat_max = 3; rand_redirect_en = 1'b1; rand_stall_en = 1'b1;
    repeat (2000) stepCycle();
    rand_redirect_en = 1'b0; rand_stall_en = 1'b0;
    repeat (8) stepCycle();

    // Misaligned redirect parks the unit until reset.
    force_target = 32'h102; force_redirect = 1'b1;
    repeat (6) stepCycle();
    checkOutput("mis_fault", misaligned_fault, 1);
    checkOutput("mis_fault_pc", fault_pc, 32'h102);
    checkOutput("mis_valid", instr_valid, 0);
    checkOutput("mis_req", imem_bus.imem_req, 0);
    lat_min = 0; lat_max = 0;
    doReset();
    waitValid("after_fault");
    checkOutput("after_fault_pc", instr_pc, 32'h0);
    checkOutput("after_fault_flag", misaligned_fault, 0);
    repeat (4) stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
